// File: rtl/cla_adder_checker.sv
// Exhaustive stimulus/response checker for a registered CLA adder: sweeps every
// {A, B, Cin}, compares latency-matched expected sums and reports errors.
module cla_adder_checker #(
  parameter int unsigned WIDTH   = 4,
  parameter int unsigned LATENCY = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  output logic [WIDTH-1:0]     A,
  output logic [WIDTH-1:0]     B,
  output logic                 Cin,
  input  logic [WIDTH-1:0]     S,
  input  logic                 Cout,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [2*WIDTH+1:0]   err_count,
  output logic [2*WIDTH:0]     first_err_vec,
  output logic                 first_err_valid
);

  localparam int unsigned VW   = 2 * WIDTH + 1;
  localparam int unsigned RW   = WIDTH + 1;
  localparam int unsigned EW   = 2 * WIDTH + 2;
  localparam int unsigned NVEC = 2 ** VW;
  localparam int unsigned DW   = $clog2(LATENCY + 1);
  localparam int unsigned LAST = LATENCY - 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;

  logic [VW-1:0]     r_cnt;
  logic [DW-1:0]     r_drain;
  logic [WIDTH-1:0]  r_a;
  logic [WIDTH-1:0]  r_b;
  logic              r_cin;
  logic              r_busy;
  logic              r_done;
  logic              r_pass;
  logic [EW-1:0]     r_err;
  logic [VW-1:0]     r_first_vec;
  logic              r_first_valid;

  // Delay line; element LAST is the compare stage.
  logic              r_dv   [LATENCY];
  logic [RW-1:0]     r_dexp [LATENCY];
  logic [VW-1:0]     r_didx [LATENCY];

  logic              w_first;
  logic              w_load;
  logic              w_shift;
  logic              w_push_valid;
  logic              w_last;
  logic [VW-1:0]     w_idx;
  logic [WIDTH-1:0]  w_a;
  logic [WIDTH-1:0]  w_b;
  logic              w_c;
  logic [RW-1:0]     w_exp;
  logic              w_cmp;
  logic              w_mis;

  assign w_last = (r_cnt == VW'(NVEC - 1));
  assign w_idx  = w_first ? '0 : r_cnt;
  assign w_c    = w_idx[0];
  assign w_b    = w_idx[WIDTH:1];
  assign w_a    = w_idx[2*WIDTH:WIDTH+1];
  assign w_exp  = RW'(w_a) + RW'(w_b) + RW'(w_c);

  assign w_cmp  = ((r_state == ST_DRIVE) || (r_state == ST_DRAIN)) && r_dv[LAST];
  assign w_mis  = w_cmp && ({Cout, S} != r_dexp[LAST]);

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next state and datapath strobes
  always_comb begin
    w_state_nxt  = r_state;
    w_first      = 1'b0;
    w_load       = 1'b0;
    w_shift      = 1'b0;
    w_push_valid = 1'b0;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          w_state_nxt  = ST_DRIVE;
          w_first      = 1'b1;
          w_load       = 1'b1;
          w_shift      = 1'b1;
          w_push_valid = 1'b1;
        end
      end
      ST_DRIVE: begin
        w_load       = 1'b1;
        w_shift      = 1'b1;
        w_push_valid = 1'b1;
        if (w_last) w_state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        w_shift = 1'b1;
        // One extra edge past the final compare so err_count is settled at done.
        if (r_drain == DW'(LATENCY)) w_state_nxt = ST_DONE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Vector counter, drive registers and drain counter
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt   <= '0;
      r_drain <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_cin   <= 1'b0;
    end else begin
      if (w_load) begin
        r_cnt <= w_idx + VW'(1);
        r_a   <= w_a;
        r_b   <= w_b;
        r_cin <= w_c;
      end
      if ((r_state == ST_DRAIN) && (w_state_nxt == ST_DRAIN)) r_drain <= r_drain + DW'(1);
      else                                                    r_drain <= '0;
    end
  end

  // Expected-value delay line
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(LATENCY); i++) begin
        r_dv[i]   <= 1'b0;
        r_dexp[i] <= '0;
        r_didx[i] <= '0;
      end
    end else if (w_shift) begin
      r_dv[0]   <= w_push_valid;
      r_dexp[0] <= w_exp;
      r_didx[0] <= w_idx;
      for (int i = 1; i < int'(LATENCY); i++) begin
        r_dv[i]   <= r_dv[i-1];
        r_dexp[i] <= r_dexp[i-1];
        r_didx[i] <= r_didx[i-1];
      end
    end
  end

  // Error accounting and status flags
  always_ff @(posedge clk) begin
    if (rst) begin
      r_err         <= '0;
      r_first_vec   <= '0;
      r_first_valid <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_pass        <= 1'b0;
    end else begin
      r_busy <= (w_state_nxt == ST_DRIVE) || (w_state_nxt == ST_DRAIN);
      r_done <= (w_state_nxt == ST_DONE);
      if (w_first) begin
        r_err         <= '0;
        r_first_vec   <= '0;
        r_first_valid <= 1'b0;
        r_pass        <= 1'b0;
      end else begin
        if (w_mis) begin
          r_err <= r_err + EW'(1);
          if (!r_first_valid) begin
            r_first_vec   <= r_didx[LAST];
            r_first_valid <= 1'b1;
          end
        end
        if ((r_state == ST_DRAIN) && (w_state_nxt == ST_DONE)) r_pass <= (r_err == '0);
      end
    end
  end

  assign A               = r_a;
  assign B               = r_b;
  assign Cin             = r_cin;
  assign busy            = r_busy;
  assign done            = r_done;
  assign pass            = r_pass;
  assign err_count       = r_err;
  assign first_err_vec   = r_first_vec;
  assign first_err_valid = r_first_valid;

endmodule

// File: tb/tb_cla_adder_checker.sv
// Bench for cla_adder_checker: a configurable registered adder on the loop-back,
// with a sweep-level model predicting every checker output each cycle.
module tb_cla_adder_checker;

  localparam int W     = 4;
  localparam int L     = 3;
  localparam int NVEC  = 512;
  localparam int SWEEP = NVEC + L;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [W-1:0]     A, B, S;
  logic             Cin, Cout;
  logic             busy, done, pass;
  logic [2*W+1:0]   err_count;
  logic [2*W:0]     first_err_vec;
  logic             first_err_valid;

  int errors = 0;
  int checks = 0;
  int cyc    = -1;   // -1: idle after reset; 0..SWEEP-1: sweeping; SWEEP: done
  int mode   = 0;    // 0 ideal, 1 S[0] stuck 0, 2 Cout stuck 0, 3 latency 2
  int ncum [NVEC];
  int first_idx;

  cla_adder_checker #(.WIDTH(W), .LATENCY(L)) dut (
    .clk(clk), .rst(rst), .start(start),
    .A(A), .B(B), .Cin(Cin), .S(S), .Cout(Cout),
    .busy(busy), .done(done), .pass(pass),
    .err_count(err_count), .first_err_vec(first_err_vec),
    .first_err_valid(first_err_valid)
  );

  always #5 clk = ~clk;

  // Adder under test: input register + output register, with injectable faults.
  logic [W-1:0] ra, rb;
  logic         rc;
  logic [W:0]   rsum;
  logic [W:0]   sel;

  always @(posedge clk) begin
    ra   <= A;
    rb   <= B;
    rc   <= Cin;
    rsum <= 5'(ra) + 5'(rb) + 5'(rc);
  end

  always_comb begin
    sel = (mode == 3) ? (5'(ra) + 5'(rb) + 5'(rc)) : rsum;
    if (mode == 1) sel[0] = 1'b0;
    if (mode == 2) sel[W] = 1'b0;
    {Cout, S} = sel;
  end

  function automatic int ideal(input int k);
    return k / (1 << (W + 1)) + (k / 2) % (1 << W) + k % 2;
  endfunction

  // What the faulty adder hands back for the compare of vector k.
  function automatic int seen(input int k, input int m);
    case (m)
      1:       return ideal(k) - ideal(k) % 2;
      2:       return ideal(k) % (1 << W);
      3:       return ideal((k < NVEC - 1) ? k + 1 : k);
      default: return ideal(k);
    endcase
  endfunction

  task automatic build_model(input int m);
    int n;
    n = 0;
    first_idx = -1;
    for (int k = 0; k < NVEC; k++) begin
      if (seen(k, m) != ideal(k)) begin
        n++;
        if (first_idx < 0) first_idx = k;
      end
      ncum[k] = n;
    end
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cyc %0d, t=%0t)", name, act, exp, cyc, $time);
    end
  endtask

  task automatic check_cycle();
    int v, nerr;
    v    = (cyc < 0) ? 0 : ((cyc < NVEC) ? cyc : NVEC - 1);
    nerr = (cyc >= L) ? ncum[(cyc - L < NVEC) ? cyc - L : NVEC - 1] : 0;
    chk("A", int'(A), v / (1 << (W + 1)));
    chk("B", int'(B), (v / 2) % (1 << W));
    chk("Cin", int'(Cin), v % 2);
    chk("busy", int'(busy), int'(cyc >= 0 && cyc < SWEEP));
    chk("done", int'(done), int'(cyc >= SWEEP));
    chk("pass", int'(pass), int'(cyc >= SWEEP && nerr == 0));
    chk("err_count", int'(err_count), nerr);
    chk("first_err_valid", int'(first_err_valid), int'(nerr > 0));
    chk("first_err_vec", int'(first_err_vec), (nerr > 0) ? first_idx : 0);
  endtask

  // One clock: sample controls at the edge, advance the model, compare, return at negedge.
  task automatic step();
    logic st, rs;
    @(posedge clk);
    st = start;
    rs = rst;
    #1;
    if (rs)                                     cyc = -1;
    else if (st && (cyc < 0 || cyc >= SWEEP))   cyc = 0;
    else if (cyc >= 0 && cyc < SWEEP)           cyc++;
    check_cycle();
    @(negedge clk);
  endtask

  task automatic wait_done(output int nbusy);
    int guard;
    nbusy = 0;
    guard = 0;
    while (!done && guard < 4 * NVEC) begin
      if (busy) nbusy++;
      step();
      guard++;
    end
    if (!done) chk("done_timeout", 0, 1);
  endtask

  task automatic run_sweep(input int m, input bit hold, output int nbusy);
    mode = m;
    build_model(m);
    start = 1'b1;
    step();
    if (!hold) start = 1'b0;
    wait_done(nbusy);
  endtask

  initial begin
    int nb;
    rst   = 1'b1;
    start = 1'b0;
    step();
    step();
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_err", int'(err_count), 0);
    rst = 1'b0;
    step();

    run_sweep(0, 1'b0, nb);
    chk("ideal_busy_cycles", nb, 515);
    chk("ideal_pass", int'(pass), 1);
    chk("ideal_err", int'(err_count), 0);
    chk("ideal_fvalid", int'(first_err_valid), 0);
    step();

    run_sweep(1, 1'b0, nb);
    chk("s0_err", int'(err_count), 256);
    chk("s0_fvec", int'(first_err_vec), 1);
    chk("s0_pass", int'(pass), 0);
    step();

    run_sweep(2, 1'b0, nb);
    chk("cout_err", int'(err_count), 256);
    chk("cout_pass", int'(pass), 0);
    step();

    run_sweep(3, 1'b0, nb);
    chk("lat2_err_nonzero", int'(err_count != '0), 1);
    chk("lat2_pass", int'(pass), 0);
    step();

    // Reset in the middle of DRIVE, once the counter has reached 100.
    mode = 0;
    build_model(0);
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (99) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_A", int'(A), 0);
    chk("midrst_Cin", int'(Cin), 0);
    chk("midrst_err", int'(err_count), 0);
    step();
    run_sweep(0, 1'b0, nb);
    chk("after_rst_busy_cycles", nb, 515);
    chk("after_rst_pass", int'(pass), 1);
    step();

    // start held high across a full sweep, then restarting from DONE.
    run_sweep(0, 1'b1, nb);
    chk("held_busy_cycles", nb, 515);
    chk("held_done", int'(done), 1);
    step();
    chk("held_restart_busy", int'(busy), 1);
    chk("held_restart_done", int'(done), 0);
    start = 1'b0;
    wait_done(nb);
    chk("held_second_pass", int'(pass), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
